// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IM/DM single-port memory arbiter.
// Optional build macro: ARB_RR_EN (round-robin on contention instead of fixed DM priority).
package mem_port_arbiter_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_IM = 2'd1,
      WAIT_DM = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IM = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_port_arbiter_arb_select.sv
// Two-way requester selector: fixed DM priority, or round-robin when ARB_RR_EN is defined.
// Optional build macro: ARB_RR_EN (adds the last-grant input).
module mem_port_arbiter_arb_select
   import mem_port_arbiter_pkg::*;
(
   input  logic   i_im_req,
   input  logic   i_dm_req,
`ifdef ARB_RR_EN
   input  owner_t i_last,
`endif
   output logic   o_any,
   output owner_t o_sel
);

   // NOTE: every output gets a default first so no path through this block can infer a latch.
   always_comb begin
      o_any = i_im_req | i_dm_req;
      o_sel = OWN_IM;
      if (i_im_req && i_dm_req) begin
`ifdef ARB_RR_EN
         o_sel = (i_last == OWN_IM) ? OWN_DM : OWN_IM;
`else
         o_sel = OWN_DM;
`endif
      end else if (i_dm_req) begin
         o_sel = OWN_DM;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (IM) and load/store (DM); one outstanding transaction.
// Optional build macro: ARB_RR_EN (round-robin on contention; default is fixed DM priority).
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                im_req,
   input  logic [ADDR_W-1:0]   im_addr,
   output logic                im_gnt,
   output logic                im_rvalid,
   output logic [DATA_W-1:0]   im_rdata,
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   input  logic [DATA_W/8-1:0] dm_be,
   output logic                dm_gnt,
   output logic                dm_rvalid,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_ready,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);

   state_t r_state;
   state_t w_state_nxt;
   logic   w_any;
   owner_t w_sel;
   logic   w_issue_ok;
   logic   w_issue;
   logic   w_accept;
   logic   w_resp;

`ifdef ARB_RR_EN
   owner_t r_last;

   always_ff @(posedge clk) begin
      if (!rst)          r_last <= OWN_IM;
      else if (w_accept) r_last <= w_sel;
   end
`endif

   mem_port_arbiter_arb_select u_arb_select (
      .i_im_req (im_req),
      .i_dm_req (dm_req),
`ifdef ARB_RR_EN
      .i_last   (r_last),
`endif
      .o_any    (w_any),
      .o_sel    (w_sel)
   );

   // A new request may issue in the same cycle the outstanding one completes.
   assign w_issue_ok = rst && ((r_state == IDLE) || mem_rvalid);
   assign w_issue    = w_issue_ok && w_any;
   assign w_accept   = w_issue && mem_ready;
   assign w_resp     = rst && mem_rvalid && (r_state != IDLE);
   assign busy       = (r_state != IDLE);

   // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_accept)    w_state_nxt = (w_sel == OWN_DM) ? WAIT_DM : WAIT_IM;
      else if (w_resp) w_state_nxt = IDLE;
   end

   always_comb begin
      mem_req   = w_issue;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      im_gnt    = w_accept && (w_sel == OWN_IM);
      dm_gnt    = w_accept && (w_sel == OWN_DM);
      im_rvalid = w_resp && (r_state == WAIT_IM);
      dm_rvalid = w_resp && (r_state == WAIT_DM);
      im_rdata  = '0;
      dm_rdata  = '0;
      if (w_issue) begin
         if (w_sel == OWN_DM) begin
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
            mem_be    = dm_be;
         end else begin
            mem_addr  = im_addr;
            mem_be    = '1;
         end
      end
      if (im_rvalid) im_rdata = mem_rdata;
      if (dm_rvalid) dm_rdata = mem_rdata;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a queue-based model of the outstanding transaction.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          im_req;
   logic [AW-1:0] im_addr;
   logic          im_gnt, im_rvalid;
   logic [DW-1:0] im_rdata;
   logic          dm_req, dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic [BW-1:0] dm_be;
   logic          dm_gnt, dm_rvalid;
   logic [DW-1:0] dm_rdata;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [BW-1:0] mem_be;
   logic          mem_ready, mem_rvalid;
   logic [DW-1:0] mem_rdata;
   logic          busy;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt), .im_rvalid(im_rvalid), .im_rdata(im_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

`ifdef ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   int  checks = 0;
   int  errors = 0;
   bit  chk_en = 1'b0;
   int  q[$];           // owners of accepted, not yet answered requests: 0 = IM, 1 = DM
   int  last_g = 0;     // owner of the most recent accepted grant
   bit  e_im_gnt = 1'b0;
   bit  e_dm_gnt = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: compare all outputs at the falling edge, then advance the queue.
   always @(negedge clk) begin
      bit resp, can, acc, ereq;
      int win, head;
      logic [31:0] ea, ew, ebe, ewe, eir, edr;
      if (chk_en) begin
         head = (q.size() > 0) ? q[0] : -1;
         resp = rst && mem_rvalid && (head >= 0);
         can  = rst && ((head < 0) || mem_rvalid);
         if (im_req && dm_req) win = RR ? ((last_g == 0) ? 1 : 0) : 1;
         else                  win = dm_req ? 1 : 0;
         ereq = can && (im_req || dm_req);
         acc  = ereq && mem_ready;
         ea = 0; ew = 0; ebe = 0; ewe = 0;
         if (ereq && win == 1) begin
            ea = dm_addr; ew = dm_wdata; ebe = 32'(dm_be); ewe = 32'(dm_we);
         end else if (ereq) begin
            ea = im_addr; ebe = 32'((1 << BW) - 1);
         end
         e_im_gnt = acc && (win == 0);
         e_dm_gnt = acc && (win == 1);
         eir = (resp && head == 0) ? mem_rdata : 0;
         edr = (resp && head == 1) ? mem_rdata : 0;
         check("mem_req",   32'(mem_req),   32'(ereq));
         check("mem_we",    32'(mem_we),    ewe);
         check("mem_addr",  mem_addr,       ea);
         check("mem_wdata", mem_wdata,      ew);
         check("mem_be",    32'(mem_be),    ebe);
         check("im_gnt",    32'(im_gnt),    32'(e_im_gnt));
         check("dm_gnt",    32'(dm_gnt),    32'(e_dm_gnt));
         check("im_rvalid", 32'(im_rvalid), 32'(resp && head == 0));
         check("dm_rvalid", 32'(dm_rvalid), 32'(resp && head == 1));
         check("im_rdata",  im_rdata,       eir);
         check("dm_rdata",  dm_rdata,       edr);
         check("busy",      32'(busy),      32'(q.size() > 0));
         if (!rst) begin
            q.delete();
            last_g = 0;
         end else begin
            if (resp) void'(q.pop_front());
            if (acc) begin
               q.push_back(win);
               last_g = win;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; im_req = 0; im_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0;
      dm_wdata = 0; dm_be = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
      chk_en = 1'b1;
      tick(); tick();
      settle();
      check("rst_busy", 32'(busy), 0);
      check("rst_gnt",  32'({im_gnt, dm_gnt, im_rvalid, dm_rvalid}), 0);
      tick(); rst = 1'b1;
      settle();
      check("post_rst_busy", 32'(busy), 0);

      // Single load
      tick(); dm_req = 1; dm_we = 0; dm_addr = 32'h100; mem_ready = 1;
      settle();
      check("ld_gnt",  32'(dm_gnt), 1);
      check("ld_addr", mem_addr, 32'h100);
      tick(); dm_req = 0;
      settle();
      check("ld_busy", 32'(busy), 1);
      check("ld_early_rv", 32'(dm_rvalid), 0);
      tick(); mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
      settle();
      check("ld_rvalid", 32'(dm_rvalid), 1);
      check("ld_rdata",  dm_rdata, 32'hDEADBEEF);
      check("ld_im_rv",  32'(im_rvalid), 0);
      tick(); mem_rvalid = 0;
      settle();
      check("ld_idle", 32'(busy), 0);

      // Contention: DM first, IM granted in the DM response cycle
      tick(); im_req = 1; im_addr = 32'h0; dm_req = 1; dm_addr = 32'h200;
      settle();
      check("ct_dm_gnt", 32'(dm_gnt), 1);
      check("ct_im_gnt", 32'(im_gnt), 0);
      check("ct_addr",   mem_addr, 32'h200);
      tick(); dm_req = 0;
      settle();
      check("ct_wait", 32'(im_gnt), 0);
      tick(); mem_rvalid = 1; mem_rdata = 32'h11111111;
      settle();
      check("ct_dm_rv",  32'(dm_rvalid), 1);
      check("ct_im_gnt2", 32'(im_gnt), 1);
      check("ct_im_addr", mem_addr, 32'h0);
      check("ct_im_be",   32'(mem_be), 32'hF);
      tick(); im_req = 0; mem_rdata = 32'h22222222;
      settle();
      check("ct_im_rv",   32'(im_rvalid), 1);
      check("ct_im_data", im_rdata, 32'h22222222);
      tick(); mem_rvalid = 0;

      // Continuous contention with 1-cycle memory
      tick(); im_req = 1; im_addr = 32'h4; dm_req = 1; dm_addr = 32'h300;
      for (int k = 0; k < 4; k++) begin
         mem_rvalid = (k > 0);
         settle();
         check("cc_dm_gnt", 32'(dm_gnt), RR ? 32'(k % 2 == 0) : 1);
         check("cc_im_gnt", 32'(im_gnt), RR ? 32'(k % 2 == 1) : 0);
         tick();
      end
      im_req = 0; dm_req = 0; mem_rvalid = 1;
      tick(); mem_rvalid = 0;

      // Backpressure on a store
      tick(); dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'h55; dm_be = 4'b0011; mem_ready = 0;
      for (int k = 0; k < 3; k++) begin
         settle();
         check("bp_no_gnt", 32'(dm_gnt), 0);
         check("bp_fields", {mem_addr[15:0], mem_wdata[7:0], 3'b0, mem_we, mem_be}, 32'h0040_5513);
         tick();
      end
      mem_ready = 1;
      settle();
      check("bp_gnt", 32'(dm_gnt), 1);
      tick(); dm_req = 0; dm_we = 0;
      tick(); mem_rvalid = 1;
      settle();
      check("bp_ack", 32'(dm_rvalid), 1);
      tick(); mem_rvalid = 0;

      // Reset while WAIT_IM
      tick(); im_req = 1; im_addr = 32'h80;
      settle();
      check("rs_gnt", 32'(im_gnt), 1);
      tick(); im_req = 0; rst = 0;
      tick(); rst = 1; mem_rvalid = 1; mem_rdata = 32'hCAFE0000;
      settle();
      check("rs_im_rv", 32'(im_rvalid), 0);
      check("rs_busy",  32'(busy), 0);
      tick(); mem_rvalid = 0;

      // Spurious response while idle
      tick(); mem_rvalid = 1;
      settle();
      check("sp_rv", 32'({im_rvalid, dm_rvalid}), 0);
      tick(); mem_rvalid = 0;
      settle();
      check("sp_idle", 32'(busy), 0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         tick();
         rst = ($urandom_range(0, 199) != 0);
         if (im_req && !e_im_gnt) begin
            if ($urandom_range(0, 9) == 0) im_req = 0;
         end else begin
            im_req  = 1'($urandom_range(0, 1));
            im_addr = $urandom;
         end
         if (dm_req && !e_dm_gnt) begin
            if ($urandom_range(0, 9) == 0) dm_req = 0;
         end else begin
            dm_req   = 1'($urandom_range(0, 1));
            dm_we    = 1'($urandom_range(0, 1));
            dm_addr  = $urandom;
            dm_wdata = $urandom;
            dm_be    = 4'($urandom_range(0, 15));
         end
         mem_ready  = ($urandom_range(0, 9) < 7);
         mem_rvalid = (q.size() > 0) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) == 0);
         mem_rdata  = $urandom;
      end

      tick();
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter sharing one single-port memory between instruction fetch (IM) and load/store (DM) requesters of the RISC-V core. It accepts per-requester requests, selects one, issues it to memory, tracks the single outstanding transaction, and routes the response back to its owner. It sits between the fetch/MEM stages and the unified memory, consuming the decoded DM enable/write strobes.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- im_req  in  1  fetch request, held with im_addr until im_gnt
- im_addr  in  ADDR_W  fetch address
- im_gnt  out  1  fetch request accepted by memory this cycle
- im_rvalid  out  1  fetch data valid
- im_rdata  out  DATA_W  fetch data
- dm_req  in  1  load/store request (from DM enable), held until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_be  in  DATA_W/8  store byte enables
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  load data valid or store completion
- dm_rdata  out  DATA_W  load data
- mem_req  out  1  request to memory
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  request fields
- mem_ready  in  1  memory accepts request when mem_req && mem_ready
- mem_rvalid  in  1  response/completion for the outstanding request (reads and writes)
- mem_rdata  in  DATA_W  read data
- busy  out  1  a transaction is outstanding

## Operation
- States: IDLE, WAIT_IM, WAIT_DM; at most one outstanding transaction.
- Issue allowed in IDLE, or in WAIT_* during the cycle mem_rvalid arrives (back-to-back).
- When issue allowed and any req: mem_req=1, fields muxed from selected requester; for IM, mem_we=0, mem_be=all ones, mem_wdata=0.
- Selection with both requesting: DM wins (fixed priority; see Configuration).
- On mem_req && mem_ready: selected *_gnt=1 (same cycle, combinational), state -> WAIT_IM/WAIT_DM per owner.
- mem_ready=0: no grant, state unchanged, request re-presented next cycle (selection re-evaluated).
- In WAIT_x with mem_rvalid: x_rvalid=1, x_rdata=mem_rdata (same cycle); state -> IDLE unless new issue accepted that cycle.
- mem_rvalid in IDLE: ignored, no rvalid raised.
- Requester dropping req before gnt: legal; nothing issued for it.
- Outputs when inactive: mem_* fields 0, rdata 0.

## Timing
- Reset (rst=0 at clock edge): state IDLE, last-grant register = IM, busy=0; all grants/rvalids 0 during and after reset until a request.
- Reset mid-transaction: outstanding response discarded; later mem_rvalid ignored.
- Grant latency: 0 cycles from request when allowed and mem_ready=1.
- Response latency: mem_rvalid to x_rvalid 0 cycles; mem_rvalid earliest 1 cycle after acceptance.
- Peak throughput: one transaction per cycle with 1-cycle memory.
- busy = state != IDLE (registered).

## Configuration
- ARB_RR_EN defined: on contention, grant the requester not granted most recently (last-grant register updated on every accepted grant); single requester always wins.
- ARB_RR_EN undefined: fixed DM priority; last-grant register absent; IM can starve under continuous DM traffic (pipeline guarantees this does not persist).

## Structure
- Shared package: state enum (IDLE/WAIT_IM/WAIT_DM), owner enum (OWN_IM/OWN_DM), default widths.
- One sub-module natural: arb_select (combinational two-way selector with optional round-robin pointer input); FSM and routing in top.

## Test plan
- Single load: dm_req, dm_we=0, dm_addr=0x100, mem_ready=1, mem_rvalid 2 cycles later with 0xDEADBEEF -> dm_gnt cycle 0, dm_rvalid with 0xDEADBEEF cycle 2, im_rvalid never.
- Contention: im_req and dm_req together at 0x0/0x200 -> dm_gnt first; im_gnt in the mem_rvalid cycle of DM; without ARB_RR_EN, continuous dm_req blocks IM.
- Round-robin (ARB_RR_EN): both requesting continuously with 1-cycle memory -> grants alternate DM, IM, DM, IM.
- Backpressure: mem_ready=0 for 3 cycles with dm store 0x55 to 0x40 be=0b0011 -> no gnt, mem fields stable; gnt on 4th cycle, store ack gives dm_rvalid.
- Reset mid-op: rst=0 while WAIT_IM, then mem_rvalid arrives after reset -> im_rvalid stays 0, busy=0.
- Spurious response: mem_rvalid in IDLE -> no rvalid on either port, state IDLE.
